// File: rtl/sfu_add_arbiter.sv
// Round-robin share of one fp16 add/sub pipe among NUM_REQ requesters.
// Define SFU_ADD_ARB_STATS_EN to add issue/stall counters.
module sfu_add_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 2,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][15:0] req_op_a,
  input  logic [NUM_REQ-1:0][15:0] req_op_b,
  input  logic [NUM_REQ-1:0]       req_mode,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [NUM_REQ-1:0][15:0] rsp_data,
  output logic                     add_issue,
  output logic [15:0]              add_op_a,
  output logic [15:0]              add_op_b,
  output logic                     add_mode,
  input  logic [15:0]              add_res,
  output logic                     busy
`ifdef SFU_ADD_ARB_STATS_EN
  ,
  output logic [31:0]              stat_issue_cnt,
  output logic [31:0]              stat_stall_cnt
`endif
);

  logic [IDX_W-1:0]                ptr_q, ptr_d;
  logic [PIPE_LAT-1:0]             tag_v_q;
  logic [PIPE_LAT-1:0][IDX_W-1:0]  tag_idx_q;
  logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][15:0]        rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]              inflight;
  logic [NUM_REQ-1:0]              elig;
  logic                            gnt;
  logic [IDX_W-1:0]                gnt_idx;

  function automatic logic [IDX_W-1:0] rr_idx(
    input logic [IDX_W-1:0] p,
    input int               k
  );
    int s;
    s = (int'(p) + k) % NUM_REQ;
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    inflight = '0;
    for (int s = 0; s < PIPE_LAT; s++) begin
      if (tag_v_q[s]) inflight[tag_idx_q[s]] = 1'b1;
    end
  end

  assign elig = req_valid & ~inflight & ~rsp_valid_q;

  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt && elig[rr_idx(ptr_q, k)]) begin
        gnt     = 1'b1;
        gnt_idx = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    add_op_a  = '0;
    add_op_b  = '0;
    add_mode  = 1'b0;
    ptr_d     = ptr_q;
    if (gnt) begin
      req_ready[gnt_idx] = 1'b1;
      add_op_a = req_op_a[gnt_idx];
      add_op_b = req_op_b[gnt_idx];
      add_mode = req_mode[gnt_idx];
      ptr_d    = rr_idx(gnt_idx, 1);
    end
  end

  assign add_issue = gnt;

  // Last tag stage lines up with add_res.
  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    if (tag_v_q[PIPE_LAT-1]) begin
      rsp_valid_d[tag_idx_q[PIPE_LAT-1]] = 1'b1;
      rsp_data_d[tag_idx_q[PIPE_LAT-1]]  = add_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      tag_v_q     <= '0;
      tag_idx_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      tag_v_q[0]   <= gnt;
      tag_idx_q[0] <= gnt_idx;
      for (int s = 1; s < PIPE_LAT; s++) begin
        tag_v_q[s]   <= tag_v_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (|tag_v_q) | (|rsp_valid_q);

`ifdef SFU_ADD_ARB_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (gnt) issue_cnt_d = issue_cnt_q + 32'd1;
    if (!gnt && (|req_valid)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_issue_cnt = issue_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
